// File: rtl/washing_machine_ctrl_pkg.sv
// Purpose : shared state encoding for the washing machine cycle sequencer.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package washing_machine_ctrl_pkg;

    localparam int STATE_W = 3;

    // Explicit encoding so the front-end and debug tooling can decode the
    // state bus. Encoding 3'b111 is unused and recovers to IDLE.
    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        ADD_DET = 3'd2,
        WASH    = 3'd3,
        DRAIN   = 3'd4,
        SPIN    = 3'd5,
        DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/washing_machine_ctrl.sv
// Purpose : Moore FSM sequencing one wash cycle (door, soap fill, detergent,
//           wash, drain, rinse fill, rinse wash, drain, spin, done).
// Latency : one clk per transition; actuator outputs decode from state only.
// Backpressure: none; sensor/timer flags are level inputs sampled per state.
//
// Ports:
//   clk, reset (async active-low)
//   close_door, start, fill, detergent, timeout, drained, spin_timeout : status
//   door_lock, motor_on, fill_on, drain_on, done : actuator / phase outputs
//   soapWash, waterWash : registered phase flags
module washing_machine_ctrl
    import washing_machine_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic close_door,
    input  logic start,
    input  logic fill,
    input  logic detergent,
    input  logic timeout,
    input  logic drained,
    input  logic spin_timeout,
    output logic door_lock,
    output logic motor_on,
    output logic fill_on,
    output logic drain_on,
    output logic done,
    output logic soapWash,
    output logic waterWash
);

    state_t state;
    state_t state_nxt;
    logic   soap_nxt;
    logic   water_nxt;

    // Next-state and flag update. The same FILL and DRAIN states serve both
    // the soap pass and the rinse pass; the flags select which branch is taken.
    always_comb begin
        state_nxt = state;
        soap_nxt  = soapWash;
        water_nxt = waterWash;
        case (state)
            IDLE: begin
                if (start && close_door) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (fill) begin
                    if (!soapWash) begin
                        state_nxt = ADD_DET;
                        soap_nxt  = 1'b1;
                    end else begin
                        state_nxt = WASH;
                        water_nxt = 1'b1;
                    end
                end
            end
            ADD_DET: begin
                if (detergent) begin
                    state_nxt = WASH;
                end
            end
            WASH: begin
                if (timeout) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drained) begin
                    state_nxt = waterWash ? SPIN : FILL;
                end
            end
            SPIN: begin
                if (spin_timeout) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                soap_nxt  = 1'b0;
                water_nxt = 1'b0;
            end
            default: begin
                // Unused encoding: return to a clean IDLE.
                state_nxt = IDLE;
                soap_nxt  = 1'b0;
                water_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            soapWash  <= 1'b0;
            waterWash <= 1'b0;
        end else begin
            state     <= state_nxt;
            soapWash  <= soap_nxt;
            waterWash <= water_nxt;
        end
    end

    // Output decode from the state register only: no input-to-output paths.
    always_comb begin
        door_lock = 1'b0;
        motor_on  = 1'b0;
        fill_on   = 1'b0;
        drain_on  = 1'b0;
        done      = 1'b0;
        case (state)
            FILL: begin
                door_lock = 1'b1;
                fill_on   = 1'b1;
            end
            ADD_DET: begin
                door_lock = 1'b1;
            end
            WASH: begin
                door_lock = 1'b1;
                motor_on  = 1'b1;
            end
            DRAIN: begin
                door_lock = 1'b1;
                drain_on  = 1'b1;
            end
            SPIN: begin
                door_lock = 1'b1;
                motor_on  = 1'b1;
                drain_on  = 1'b1;
            end
            DONE: begin
                // Door released on the completion pulse so it can be opened.
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_washing_machine_ctrl.sv
// Purpose : self-checking bench for washing_machine_ctrl.
// Latency : expected outputs are checked 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_washing_machine_ctrl;

    logic clk;
    logic reset;
    logic close_door, start, fill, detergent, timeout, drained, spin_timeout;
    logic door_lock, motor_on, fill_on, drain_on, done, soapWash, waterWash;

    washing_machine_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .close_door   (close_door),
        .start        (start),
        .fill         (fill),
        .detergent    (detergent),
        .timeout      (timeout),
        .drained      (drained),
        .spin_timeout (spin_timeout),
        .door_lock    (door_lock),
        .motor_on     (motor_on),
        .fill_on      (fill_on),
        .drain_on     (drain_on),
        .done         (done),
        .soapWash     (soapWash),
        .waterWash    (waterWash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input vector: {close_door, start, fill, detergent, timeout, drained, spin_timeout}
    localparam logic [6:0] I_NONE = 7'b0000000;
    localparam logic [6:0] I_DOOR = 7'b1000000;
    localparam logic [6:0] I_STRT = 7'b0100000;
    localparam logic [6:0] I_FILL = 7'b0010000;
    localparam logic [6:0] I_DET  = 7'b0001000;
    localparam logic [6:0] I_TMO  = 7'b0000100;
    localparam logic [6:0] I_DRN  = 7'b0000010;
    localparam logic [6:0] I_SPT  = 7'b0000001;
    localparam logic [6:0] I_GO   = I_DOOR | I_STRT;

    // Output vector: {door_lock, motor_on, fill_on, drain_on, done, soapWash, waterWash}
    localparam logic [6:0] E_IDLE  = 7'b0000000;
    localparam logic [6:0] E_FILL  = 7'b1010000;
    localparam logic [6:0] E_ADD   = 7'b1000000;
    localparam logic [6:0] E_WASH  = 7'b1100000;
    localparam logic [6:0] E_DRAIN = 7'b1001000;
    localparam logic [6:0] E_SPIN  = 7'b1101000;
    localparam logic [6:0] E_DONE  = 7'b0000100;
    localparam logic [6:0] F_S     = 7'b0000010;
    localparam logic [6:0] F_W     = 7'b0000001;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] exp_q[$];
    string      tag_q[$];

    function automatic logic [6:0] obs_vec();
        return {door_lock, motor_on, fill_on, drain_on, done, soapWash, waterWash};
    endfunction

    task automatic check_eq(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (dl,mo,fi,dr,dn,sw,ww)", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] iv);
        {close_door, start, fill, detergent, timeout, drained, spin_timeout} = iv;
    endtask

    task automatic pop_check();
        logic [6:0] e;
        string      t;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got no entry expected one");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_eq(t, obs_vec(), e);
        end
    endtask

    // Drive inputs (called 1 unit after an edge), record the expectation,
    // then compare once the next edge has updated the DUT.
    task automatic step(input logic [6:0] iv, input logic [6:0] exp, input string tag);
        drive(iv);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        drive(I_NONE);

        // Reset held with random inputs: everything stays 0.
        for (int i = 0; i < 2; i++) begin
            drive(7'($urandom));
            @(posedge clk);
            #1;
            exp_q.push_back(E_IDLE);
            tag_q.push_back($sformatf("reset_hold_%0d", i));
            pop_check();
        end
        drive(I_NONE);
        reset = 1'b1;
        step(I_NONE, E_IDLE, "after_reset");

        // Door interlock: start without a closed door stays idle.
        for (int i = 0; i < 5; i++) begin
            step(I_STRT, E_IDLE, $sformatf("interlock_%0d", i));
        end
        step(I_GO, E_FILL, "interlock_fill");

        // Full cycle, one-cycle pulses with a quiet cycle after each to
        // confirm each state holds until its own condition arrives.
        step(I_NONE, E_FILL,              "full_fill_dwell");
        step(I_FILL, E_ADD | F_S,         "full_add_det");
        step(I_NONE, E_ADD | F_S,         "full_add_dwell");
        step(I_DET,  E_WASH | F_S,        "full_wash1");
        step(I_NONE, E_WASH | F_S,        "full_wash1_dwell");
        step(I_TMO,  E_DRAIN | F_S,       "full_drain1");
        step(I_NONE, E_DRAIN | F_S,       "full_drain1_dwell");
        step(I_DRN,  E_FILL | F_S,        "full_rinse_fill");
        step(I_NONE, E_FILL | F_S,        "full_rinse_dwell");
        step(I_FILL, E_WASH | F_S | F_W,  "full_wash2");
        step(I_TMO,  E_DRAIN | F_S | F_W, "full_drain2");
        step(I_DRN,  E_SPIN | F_S | F_W,  "full_spin");
        step(I_NONE, E_SPIN | F_S | F_W,  "full_spin_dwell");
        step(I_SPT,  E_DONE | F_S | F_W,  "full_done");
        step(I_NONE, E_IDLE,              "full_idle");
        step(I_NONE, E_IDLE,              "full_idle_stays");

        // Cumulative levels with start and door held high throughout.
        step(I_GO,                                          E_FILL,              "cum_fill");
        step(I_GO | I_FILL,                                 E_ADD | F_S,         "cum_add_det");
        step(I_GO | I_FILL | I_DET,                         E_WASH | F_S,        "cum_wash1");
        step(I_GO | I_FILL | I_DET | I_TMO,                 E_DRAIN | F_S,       "cum_drain1");
        step(I_GO | I_FILL | I_DET | I_TMO | I_DRN,         E_FILL | F_S,        "cum_rinse_fill");
        step(7'b1111111,                                    E_WASH | F_S | F_W,  "cum_wash2");
        step(7'b1111111,                                    E_DRAIN | F_S | F_W, "cum_drain2");
        step(7'b1111111,                                    E_SPIN | F_S | F_W,  "cum_spin");
        step(7'b1111111,                                    E_DONE | F_S | F_W,  "cum_done");
        step(7'b1111111,                                    E_IDLE,              "cum_idle");
        step(7'b1111111,                                    E_FILL,              "cum_restart");
        step(7'b1111111,                                    E_ADD | F_S,         "cum_restart_add");

        // Ignored inputs in WASH: only timeout moves it on.
        step(I_NONE, E_ADD | F_S,  "ign_add_hold");
        step(I_DET,  E_WASH | F_S, "ign_wash");
        step(I_FILL | I_DOOR,           E_WASH | F_S, "ign_fill_door");
        step(I_DRN,                     E_WASH | F_S, "ign_drained");
        step(I_STRT | I_SPT | I_DET,    E_WASH | F_S, "ign_misc");
        step(I_NONE,                    E_WASH | F_S, "ign_quiet");
        step(I_TMO,                     E_DRAIN | F_S, "ign_timeout");

        // Walk to SPIN, then abort with an asynchronous reset mid-cycle.
        step(I_DRN,  E_FILL | F_S,        "abort_rinse_fill");
        step(I_FILL, E_WASH | F_S | F_W,  "abort_wash2");
        step(I_TMO,  E_DRAIN | F_S | F_W, "abort_drain2");
        step(I_DRN,  E_SPIN | F_S | F_W,  "abort_spin");
        drive(I_NONE);
        #2;
        reset = 1'b0;
        #1;
        exp_q.push_back(E_IDLE);
        tag_q.push_back("abort_async");
        pop_check();
        @(posedge clk);
        #1;
        exp_q.push_back(E_IDLE);
        tag_q.push_back("abort_held");
        pop_check();
        reset = 1'b1;
        step(I_NONE, E_IDLE, "abort_release");
        step(I_GO,   E_FILL, "abort_new_cycle");

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/washing_machine_ctrl.md
Name: washing_machine_ctrl

Overview:
Single-clock Moore FSM that sequences one wash cycle: door check, soap fill, detergent, wash, drain, rinse fill, rinse wash, drain, spin, done. Inputs are level status flags from the appliance's sensors and timers. Outputs are actuator enables and phase flags for the appliance front-end. It sits between the user-panel and sensor logic and the motor, valve and pump drivers.

Parameters:
none (state encoding lives in the shared package)

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset; low forces IDLE and clears all flags
close_door  input  1  1 = door closed
start  input  1  1 = user start request (level)
fill  input  1  1 = water level reached
detergent  input  1  1 = detergent dispensed
timeout  input  1  1 = wash/rinse timer expired
drained  input  1  1 = drum empty
spin_timeout  input  1  1 = spin timer expired
door_lock  output  1  door latch engaged
motor_on  output  1  drum motor enable
fill_on  output  1  inlet valve enable
drain_on  output  1  drain pump enable
done  output  1  one-cycle cycle-complete pulse
soapWash  output  1  soap phase reached (registered flag)
waterWash  output  1  rinse phase reached (registered flag)

Behaviour:
- The state register and the soapWash/waterWash flags update on the rising edge of clk. All other outputs decode combinationally from the state register only, with no input-to-output combinational paths.
- reset low (async): state=IDLE, soapWash=0, waterWash=0. All outputs read 0 while reset is low.
- States and transitions. Each state samples only the input it names; all other inputs are ignored.
  - IDLE: go to FILL when start=1 and close_door=1 in the same cycle; otherwise stay.
  - FILL: if fill=1 and soapWash=0, go to ADD_DET and set soapWash=1. If fill=1 and soapWash=1, go to WASH and set waterWash=1.
  - ADD_DET: go to WASH when detergent=1.
  - WASH: go to DRAIN when timeout=1.
  - DRAIN: if drained=1 and waterWash=0, go to FILL (rinse). If drained=1 and waterWash=1, go to SPIN.
  - SPIN: go to DONE when spin_timeout=1.
  - DONE: go to IDLE unconditionally after one cycle; clear soapWash and waterWash on that edge.
- Output decode (unlisted outputs are 0):
  - IDLE: all 0.
  - FILL: door_lock=1, fill_on=1.
  - ADD_DET: door_lock=1.
  - WASH: door_lock=1, motor_on=1.
  - DRAIN: door_lock=1, drain_on=1.
  - SPIN: door_lock=1, motor_on=1, drain_on=1.
  - DONE: done=1, door_lock=0.
- Latency: each transition happens on the first rising edge where its condition is high. A flag already held high gives a one-cycle dwell; for example, fill held high makes the rinse FILL last exactly 1 cycle.
- close_door and start are ignored outside IDLE. Opening the door mid-cycle has no effect because the door is locked.
- In IDLE, start=1 with close_door=0 stays in IDLE with door_lock=0.
- After DONE, if start and close_door are still high, a new cycle starts from IDLE on the next edge.
- Reset asserted mid-operation aborts immediately: all actuators go off and the flags clear.
- Unused or illegal state encodings recover to IDLE on the next edge.

Decomposition:
- Shared package: state enum (IDLE, FILL, ADD_DET, WASH, DRAIN, SPIN, DONE) with explicit 3-bit encoding.
- Single module; no sub-module needed. Use separate next-state, state/flag register, and output-decode processes.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random inputs -> all outputs 0; release -> still IDLE, all outputs 0.
- Door interlock: start=1, close_door=0 for 5 cycles -> remains IDLE, door_lock=0; then close_door=1 -> next cycle FILL, fill_on=1, door_lock=1.
- Full cycle with one-cycle pulses on fill, detergent, timeout, drained, fill, timeout, drained, spin_timeout -> state sequence FILL, ADD_DET, WASH, DRAIN, FILL, WASH, DRAIN, SPIN, DONE, IDLE. Checks: soapWash=1 from ADD_DET onward; waterWash=1 from second WASH onward; done high exactly 1 cycle; both flags 0 in IDLE.
- Cumulative levels: after start, raise fill, detergent, timeout, drained, spin_timeout one per 10 time units (one per cycle at a 10-unit clock period) and hold them high -> reaches DONE with the rinse FILL, WASH and DRAIN each lasting 1 cycle; then IDLE; if start is still high, a new cycle starts.
- Abort: assert reset=0 during SPIN -> motor_on, drain_on, door_lock drop asynchronously; flags 0; after release, IDLE.
- Ignored inputs: in WASH, toggle fill, drained, close_door -> state unchanged until timeout=1.
